// File: rtl/pwm_capture_if.sv
// Measurement bundle of pwm_capture: the raw PWM pin in, the duty/period report out.
// The master side is the capture block, the slave side is whoever drives the pin and reads results.
interface pwm_capture_if #(
    parameter int CNT_W = 16
);
    logic             pwm_in;
    logic [7:0]       duty;
    logic             duty_valid;
    logic [CNT_W-1:0] period;
    logic             active;
    logic             overrun;

    modport master (
        input  pwm_in,
        output duty, duty_valid, period, active, overrun
    );

    modport slave (
        output pwm_in,
        input  duty, duty_valid, period, active, overrun
    );
endinterface

// File: rtl/pwm_capture.sv
// Duty-cycle meter: synchronises a PWM pin, times high/period between rising edges and reports duty in percent.
// Define PWM_CAP_FILTER_EN to insert a 3-tap majority glitch filter after the synchroniser.
module pwm_capture #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 60000
) (
    input  logic          clk,
    input  logic          rst_n,
    pwm_capture_if.master bus
);
    localparam int DW  = CNT_W + 7;
    localparam int DCW = $clog2(DW);
    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

    localparam logic [1:0] ST_SYNC = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic level_q, level_d;
    logic rise_q, rise_d;
    logic clean;
`ifdef PWM_CAP_FILTER_EN
    logic tap1_q, tap1_d;
    logic tap2_q, tap2_d;
    logic filt_q, filt_d;
`endif

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
    logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
    logic             timed_out_q, timed_out_d;
    logic [DW-1:0]    num_q, num_d;
    logic [CNT_W-1:0] den_q, den_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [DW-1:0]    quo_q, quo_d;
    logic [DCW-1:0]   div_cnt_q, div_cnt_d;
    logic [7:0]       duty_q, duty_d;
    logic             duty_valid_q, duty_valid_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             active_q, active_d;
    logic             overrun_q, overrun_d;

    logic [CNT_W:0]   rem_shift;
    logic             q_bit;
    logic [DW-1:0]    quo_next;
    logic             tmo_hit;

    // level_q and rise_q become valid on the same edge, so the rise cycle counts as the first high cycle
    always_comb begin
        meta_d  = bus.pwm_in;
        sync_d  = meta_q;
`ifdef PWM_CAP_FILTER_EN
        tap1_d  = sync_q;
        tap2_d  = tap1_q;
        filt_d  = (sync_q & tap1_q) | (sync_q & tap2_q) | (tap1_q & tap2_q);
        clean   = filt_q;
`else
        clean   = sync_q;
`endif
        level_d = clean;
        rise_d  = clean & ~level_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
`ifdef PWM_CAP_FILTER_EN
            tap1_q  <= 1'b0;
            tap2_q  <= 1'b0;
            filt_q  <= 1'b0;
`endif
        end else begin
            meta_q  <= meta_d;
            sync_q  <= sync_d;
            level_q <= level_d;
            rise_q  <= rise_d;
`ifdef PWM_CAP_FILTER_EN
            tap1_q  <= tap1_d;
            tap2_q  <= tap2_d;
            filt_q  <= filt_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        period_cnt_d = period_cnt_q;
        high_cnt_d   = high_cnt_q;
        timed_out_d  = timed_out_q;
        num_d        = num_q;
        den_d        = den_q;
        rem_d        = rem_q;
        quo_d        = quo_q;
        div_cnt_d    = div_cnt_q;
        duty_d       = duty_q;
        duty_valid_d = 1'b0;
        period_d     = period_q;
        active_d     = active_q;
        overrun_d    = overrun_q;

        rem_shift = {rem_q, num_q[DW-1]};
        q_bit     = (rem_shift >= {1'b0, den_q});
        quo_next  = {quo_q[DW-2:0], q_bit};
        // A timeout seen during a divide simply waits: the counter stays saturated until RUN resumes
        tmo_hit   = (period_cnt_q == TMO) && !timed_out_q && !rise_q && (state_q != ST_DIV);

        if (rise_q) begin
            period_cnt_d = CNT_W'(1);
            high_cnt_d   = CNT_W'(1);
            timed_out_d  = 1'b0;
        end else begin
            if (period_cnt_q != TMO)
                period_cnt_d = period_cnt_q + 1'b1;
            if (level_q && (high_cnt_q != TMO))
                high_cnt_d = high_cnt_q + 1'b1;
        end

        case (state_q)
            ST_SYNC: begin
                if (rise_q)
                    state_d = ST_RUN;
            end
            ST_RUN: begin
                if (rise_q) begin
                    num_d     = DW'(high_cnt_q) * DW'(100);
                    den_d     = period_cnt_q;
                    rem_d     = '0;
                    quo_d     = '0;
                    div_cnt_d = '0;
                    state_d   = ST_DIV;
                end
            end
            ST_DIV: begin
                if (rise_q)
                    overrun_d = 1'b1;
                rem_d     = q_bit ? CNT_W'(rem_shift - {1'b0, den_q}) : rem_shift[CNT_W-1:0];
                num_d     = num_q << 1;
                quo_d     = quo_next;
                div_cnt_d = div_cnt_q + 1'b1;
                if (div_cnt_q == DCW'(DW - 1)) begin
                    duty_d       = (quo_next > DW'(100)) ? 8'd100 : quo_next[7:0];
                    period_d     = den_q;
                    active_d     = (duty_d != 8'd0);
                    duty_valid_d = 1'b1;
                    state_d      = ST_RUN;
                end
            end
            default: state_d = ST_SYNC;
        endcase

        if (tmo_hit) begin
            duty_d       = level_q ? 8'd100 : 8'd0;
            active_d     = level_q;
            period_d     = '0;
            duty_valid_d = 1'b1;
            timed_out_d  = 1'b1;
            state_d      = ST_SYNC;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_SYNC;
            period_cnt_q <= '0;
            high_cnt_q   <= '0;
            timed_out_q  <= 1'b0;
            num_q        <= '0;
            den_q        <= '0;
            rem_q        <= '0;
            quo_q        <= '0;
            div_cnt_q    <= '0;
            duty_q       <= '0;
            duty_valid_q <= 1'b0;
            period_q     <= '0;
            active_q     <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            period_cnt_q <= period_cnt_d;
            high_cnt_q   <= high_cnt_d;
            timed_out_q  <= timed_out_d;
            num_q        <= num_d;
            den_q        <= den_d;
            rem_q        <= rem_d;
            quo_q        <= quo_d;
            div_cnt_q    <= div_cnt_d;
            duty_q       <= duty_d;
            duty_valid_q <= duty_valid_d;
            period_q     <= period_d;
            active_q     <= active_d;
            overrun_q    <= overrun_d;
        end
    end

    assign bus.duty       = duty_q;
    assign bus.duty_valid = duty_valid_q;
    assign bus.period     = period_q;
    assign bus.active     = active_q;
    assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: each driven period queues its expected duty, popped on every duty_valid.
// Uses a shortened TIMEOUT so static-line cases stay short.
module tb_pwm_capture;
    localparam int CNT_W = 16;
    localparam int TMO   = 6000;
`ifdef PWM_CAP_FILTER_EN
    localparam bit FILTER_ON = 1'b1;
`else
    localparam bit FILTER_ON = 1'b0;
`endif

    typedef struct {
        int duty;
        int period;
        int active;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   prevP  = 0;
    int   prevH  = 0;

    pwm_capture_if #(.CNT_W(CNT_W)) bus ();

    pwm_capture #(.CNT_W(CNT_W), .TIMEOUT(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #10 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic pushExpect(input int duty, input int period);
        exp_t e;
        e.duty   = duty;
        e.period = period;
        e.active = (duty != 0) ? 1 : 0;
        sb.push_back(e);
    endtask

    task automatic pushMeasure(input int p, input int h);
        int d;
        d = (h * 100) / p;
        if (d > 100) d = 100;
        pushExpect(d, p);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One PWM period starting with a rising edge; that edge closes the previous period
    task automatic applyStimulus(input int p, input int h, input bit measurePrev);
        if (measurePrev) pushMeasure(prevP, prevH);
        prevP = p;
        prevH = h;
        bus.pwm_in = 1'b1;
        tick(h);
        bus.pwm_in = 1'b0;
        tick(p - h);
    endtask

    task automatic holdLine(input logic level, input int cycles);
        bus.pwm_in = level;
        tick(cycles);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.duty_valid) begin
            checkOutput("valid_expected", (sb.size() > 0) ? 1 : 0, 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checkOutput("duty", int'(bus.duty), e.duty);
                checkOutput("period", int'(bus.period), e.period);
                checkOutput("active", int'(bus.active), e.active);
            end
        end
    end

    initial begin
        int hs[8];
        hs = '{5, 13, 7, 19, 3, 11, 17, 9};
        bus.pwm_in = 1'b0;
        rst_n      = 1'b0;
        tick(3);
        checkOutput("rst_duty", int'(bus.duty), 0);
        checkOutput("rst_valid", int'(bus.duty_valid), 0);
        checkOutput("rst_period", int'(bus.period), 0);
        checkOutput("rst_active", int'(bus.active), 0);
        checkOutput("rst_overrun", int'(bus.overrun), 0);
        rst_n = 1'b1;
        tick(5);

        $display("[TB] 50%% duty, period 5000");
        for (int i = 0; i < 4; i++) applyStimulus(5000, 2500, i > 0);
        checkOutput("active_run", int'(bus.active), 1);
        checkOutput("period_run", int'(bus.period), 5000);

        $display("[TB] truncation and near-100%% duty");
        applyStimulus(5000, 1234, 1'b1);
        applyStimulus(5000, 4999, 1'b1);
        checkOutput("overrun_clear", int'(bus.overrun), 0);

        // Rises every 20 cycles against a 24-cycle divide: every odd burst period gets measured
        $display("[TB] period shorter than the divide");
        for (int i = 0; i < 8; i++) applyStimulus(20, hs[i], (i % 2) == 0);
        checkOutput("overrun_set", int'(bus.overrun), 1);

        $display("[TB] static low line");
        pushExpect(0, 0);
        holdLine(1'b0, TMO + 300);
        checkOutput("q_drained_lo", sb.size(), 0);
        checkOutput("active_lo", int'(bus.active), 0);

        $display("[TB] single-cycle glitches on a low line");
        for (int i = 0; i < 4; i++) applyStimulus(300, 1, (i > 0) && !FILTER_ON);
        if (!FILTER_ON) pushExpect(0, 0);
        holdLine(1'b0, TMO + 300);
        checkOutput("q_drained_glitch", sb.size(), 0);

        $display("[TB] static high line");
        pushExpect(100, 0);
        holdLine(1'b1, TMO + 300);
        checkOutput("q_drained_hi", sb.size(), 0);
        checkOutput("active_hi", int'(bus.active), 1);

        $display("[TB] reset during divide");
        holdLine(1'b0, 100);
        applyStimulus(500, 250, 1'b0);
        bus.pwm_in = 1'b1;
        tick(13);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_duty", int'(bus.duty), 0);
        checkOutput("midrst_active", int'(bus.active), 0);
        checkOutput("midrst_overrun", int'(bus.overrun), 0);
        checkOutput("midrst_period", int'(bus.period), 0);
        checkOutput("midrst_valid", int'(bus.duty_valid), 0);
        bus.pwm_in = 1'b0;
        tick(5);
        rst_n = 1'b1;
        holdLine(1'b0, 50);
        applyStimulus(1000, 300, 1'b0);
        applyStimulus(1000, 700, 1'b1);
        applyStimulus(1000, 450, 1'b1);
        applyStimulus(200, 100, 1'b1);

        for (int k = 0; (k < 200) && (sb.size() > 0); k++) tick(1);
        checkOutput("q_drained_end", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
Measures the duty cycle of an incoming PWM waveform. Reports it as an integer percentage 0..100, matching the D1/D2 duty encoding our PWM generator consumes. Sits on the sense/feedback side of the charge controller, so a measured gate drive can be compared against the commanded duty. Handles a static line (0 % / 100 %) via timeout.

Parameters:
CNT_W, 16, width of high-time and period counters
TIMEOUT, 60000, cycles without an edge before the line is declared static; must be < 2^CNT_W

Ports:
clk  input  1  system clock (50 MHz nominal)
rst_n  input  1  reset; one clock, asynchronous assert, active-low
pwm_in  input  1  asynchronous PWM input
duty  output  8  last measured duty, percent 0..100
duty_valid  output  1  one-cycle pulse when duty/period update
period  output  CNT_W  last measured period in clk cycles (0 after a timeout)
active  output  1  high when duty != 0; mirrors the generator's switch-enable rule
overrun  output  1  sticky; a completed period was dropped because the divider was busy

Behaviour:
- Reset (async, rst_n=0): duty=0, duty_valid=0, period=0, active=0, overrun=0, counters=0, FSM=SYNC. Assertion mid-divide aborts the divide with no valid pulse.
- Input path: 2-FF synchronizer, then 1-FF edge detect. rise/fall are single-cycle strobes; detection latency is 3 clk from the pin.
- Counters:
  - period_cnt increments every cycle, cleared to 1 on rise.
  - high_cnt increments while synced input is 1, cleared to 1 on rise.
  - Both saturate at TIMEOUT.
- FSM states:
  - SYNC: wait for first rise after reset/timeout; no measurement reported. -> RUN on rise.
  - RUN: on rise, if divider idle, latch H=high_cnt and P=period_cnt and start divide. If divider busy, drop the sample and set overrun.
  - DIV: restoring shift-subtract of N=H*100 (CNT_W+7 bits) by P, one quotient bit per cycle, CNT_W+7 cycles.
  - Counters keep running during DIV; FSM returns to RUN when done.
- Output timing: duty_valid pulses on cycle CNT_W+8 after the capture cycle (cycle 0). duty and period update on that same cycle.
- Arithmetic:
  - Quotient truncates toward zero.
  - Quotient >100 (impossible unless H>P) clamps to 100.
  - P=0 never captured (P>=1 by construction).
  - If period_cnt reaches TIMEOUT, the latched P value is TIMEOUT.
- Timeout: if period_cnt reaches TIMEOUT in RUN or SYNC with no rise:
  - duty=100 if synced input is 1, else 0.
  - period=0, duty_valid pulses once, FSM -> SYNC.
  - No further pulses while the line stays static.
  - A timeout occurring during DIV is deferred until the divide completes; the divide result is emitted first, and the timeout pulse follows on the next cycle.
- active = (duty != 0), registered together with duty.
- Simultaneous rise and timeout on the same cycle: rise wins; the counter is cleared.
- overrun clears only on reset.

Optional Feature:
PWM_CAP_FILTER_EN:
- Defined: a 3-tap majority glitch filter is inserted after the synchronizer. Pulses of 1 clk are rejected. Pin-to-strobe latency becomes 5 clk. All measured widths shift equally, so the period is unchanged.
- Undefined: no filter; latency is 3 clk, and a 1-clk glitch counts as an edge.

Test Plan:
- Period 5000 clk, high 2500 clk, 4 periods -> first duty_valid after the 2nd rise; duty=50, period=5000, active=1, one valid per period thereafter.
- Period 5000, high 1234 -> duty=24 (truncation); high 4999 -> duty=99; high 5000-cycle windows with one 1-clk low -> duty=99.
- pwm_in held 0 for 70000 clk after running -> exactly one valid with duty=0, period=0, active=0; then held 1 -> after a rise, timeout gives duty=100, active=1.
- Period 20 clk (shorter than the divide, 23 cycles) -> overrun=1, and every reported duty is still correct for its own period.
- rst_n dropped during DIV -> all outputs 0 immediately (asynchronous), no duty_valid. After release, no valid until two rises have occurred.
- With PWM_CAP_FILTER_EN, inject 1-clk high glitches into a 0 % line -> no rise detected, timeout reports duty=0. Without the macro, the same glitches produce rises.
